// File: rtl/l2_atomic_requester_pkg.sv
// Shared types for the L2 atomic requester: atomic ops, L2 packets, FSM states.
// Optional feature macro: L2_ATOMIC_BACKOFF_EN (adds the BACKOFF state).
package l2_atomic_requester_pkg;

    localparam int ATOMIC_WORD_WIDTH = 32;
    localparam int CACHE_LINE_BITS   = 512;
    localparam int CACHE_LINE_BYTES  = 64;

    typedef logic [ATOMIC_WORD_WIDTH-1:0] word_t;
    typedef logic [3:0]  core_id_t;
    typedef logic [1:0]  local_thread_idx_t;
    typedef logic [25:0] l2_addr_t;

    typedef enum logic [1:0] {
        ATOMIC_ADD,
        ATOMIC_SWAP,
        ATOMIC_AND,
        ATOMIC_OR
    } atomic_op_t;

    typedef enum logic {
        CT_ICACHE,
        CT_DCACHE
    } cache_type_t;

    typedef enum logic [2:0] {
        L2REQ_LOAD,
        L2REQ_STORE,
        L2REQ_LOAD_SYNC,
        L2REQ_STORE_SYNC,
        L2REQ_FLUSH,
        L2REQ_IINVALIDATE,
        L2REQ_DINVALIDATE
    } l2req_packet_type_t;

    typedef enum logic [2:0] {
        L2RSP_LOAD_ACK,
        L2RSP_STORE_ACK,
        L2RSP_FLUSH_ACK,
        L2RSP_IINVALIDATE_ACK,
        L2RSP_DINVALIDATE_ACK
    } l2rsp_packet_type_t;

    typedef struct packed {
        l2req_packet_type_t           packet_type;
        core_id_t                     core;
        local_thread_idx_t            id;
        cache_type_t                  cache_type;
        l2_addr_t                     address;
        logic [CACHE_LINE_BITS-1:0]   data;
        logic [CACHE_LINE_BYTES-1:0]  store_mask;
    } l2req_packet_t;

    typedef struct packed {
        logic                         status;
        l2rsp_packet_type_t           packet_type;
        core_id_t                     core;
        local_thread_idx_t            id;
        cache_type_t                  cache_type;
        l2_addr_t                     address;
        logic [CACHE_LINE_BITS-1:0]   data;
    } l2rsp_packet_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_REQ,
        ST_LOAD_WAIT,
        ST_STORE_REQ,
        ST_STORE_WAIT,
        ST_DONE
`ifdef L2_ATOMIC_BACKOFF_EN
        ,
        ST_BACKOFF
`endif
    } state_t;

endpackage

// File: rtl/l2_atomic_requester_alu.sv
// Combinational atomic ALU: new word from op, old word and operand.
// ADD wraps modulo 2^32.
module atomic_alu
    import l2_atomic_requester_pkg::*;
(
    input  atomic_op_t op,
    input  word_t      old_value,
    input  word_t      operand,
    output word_t      new_value
);

    always_comb begin
        new_value = old_value;
        unique case (op)
            ATOMIC_ADD:  new_value = old_value + operand;
            ATOMIC_SWAP: new_value = operand;
            ATOMIC_AND:  new_value = old_value & operand;
            ATOMIC_OR:   new_value = old_value | operand;
            default:     new_value = old_value;
        endcase
    end

endmodule

// File: rtl/l2_atomic_requester.sv
// Read-modify-write via L2 LOAD_SYNC/STORE_SYNC with retry on failed store.
// L2_ATOMIC_BACKOFF_EN: exponential backoff between failed store and reload.
module l2_atomic_requester
    import l2_atomic_requester_pkg::*;
#(
    parameter int CORE_ID     = 0,
    parameter int THREAD_ID   = 0,
    parameter int MAX_RETRIES = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  atomic_op_t    cmd_op,
    input  logic [31:0]   cmd_addr,
    input  logic [31:0]   cmd_operand,
    output logic          done_valid,
    output logic          done_success,
    output logic [31:0]   done_old_value,
    output logic [3:0]    done_retries,
    output logic          l2i_request_valid,
    output l2req_packet_t l2i_request,
    input  logic          l2_ready,
    input  logic          l2_response_valid,
    input  l2rsp_packet_t l2_response
);

    state_t     state_q, state_d;
    atomic_op_t op_q, op_d;
    logic [31:2] addr_q, addr_d;
    word_t      operand_q, operand_d;
    word_t      old_q, old_d;
    word_t      new_q, new_d;
    logic [3:0] retries_q, retries_d;
    logic       done_success_q, done_success_d;
    word_t      done_old_q, done_old_d;
    logic [3:0] done_retries_q, done_retries_d;
`ifdef L2_ATOMIC_BACKOFF_EN
    logic [15:0] backoff_q, backoff_d;
`endif

    logic       rsp_match;
    word_t      rsp_word;
    word_t      alu_result;
    logic [8:0] lane_bit;
    logic [5:0] mask_bit;
    logic       unused_bits;

    assign lane_bit = {addr_q[5:2], 5'd0};
    assign mask_bit = {addr_q[5:2], 2'd0};

    assign rsp_match = l2_response_valid
        && l2_response.core == core_id_t'(CORE_ID)
        && l2_response.id == local_thread_idx_t'(THREAD_ID)
        && l2_response.cache_type == CT_DCACHE;

    assign rsp_word = l2_response.data[lane_bit +: ATOMIC_WORD_WIDTH];
    assign unused_bits = ^{cmd_addr[1:0], l2_response.address};

    atomic_alu u_alu (
        .op        (op_q),
        .old_value (rsp_word),
        .operand   (operand_q),
        .new_value (alu_result)
    );

    assign cmd_ready      = state_q == ST_IDLE;
    assign done_valid     = state_q == ST_DONE;
    assign done_success   = done_success_q;
    assign done_old_value = done_old_q;
    assign done_retries   = done_retries_q;

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        addr_d         = addr_q;
        operand_d      = operand_q;
        old_d          = old_q;
        new_d          = new_q;
        retries_d      = retries_q;
        done_success_d = done_success_q;
        done_old_d     = done_old_q;
        done_retries_d = done_retries_q;
`ifdef L2_ATOMIC_BACKOFF_EN
        backoff_d      = backoff_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d      = cmd_op;
                    addr_d    = cmd_addr[31:2];
                    operand_d = cmd_operand;
                    retries_d = '0;
                    state_d   = ST_LOAD_REQ;
                end
            end
            ST_LOAD_REQ: begin
                if (l2_ready) state_d = ST_LOAD_WAIT;
            end
            ST_LOAD_WAIT: begin
                if (rsp_match && l2_response.packet_type == L2RSP_LOAD_ACK) begin
                    old_d   = rsp_word;
                    new_d   = alu_result;
                    state_d = ST_STORE_REQ;
                end
            end
            ST_STORE_REQ: begin
                if (l2_ready) state_d = ST_STORE_WAIT;
            end
            ST_STORE_WAIT: begin
                if (rsp_match && l2_response.packet_type == L2RSP_STORE_ACK) begin
                    if (l2_response.status || retries_q == 4'(MAX_RETRIES)) begin
                        done_success_d = l2_response.status;
                        done_old_d     = old_q;
                        done_retries_d = retries_q;
                        state_d        = ST_DONE;
                    end else begin
                        retries_d = retries_q + 4'd1;
`ifdef L2_ATOMIC_BACKOFF_EN
                        backoff_d = 16'd1 << retries_q;
                        state_d   = ST_BACKOFF;
`else
                        state_d   = ST_LOAD_REQ;
`endif
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
`ifdef L2_ATOMIC_BACKOFF_EN
            ST_BACKOFF: begin
                if (backoff_q <= 16'd1) state_d = ST_LOAD_REQ;
                else backoff_d = backoff_q - 16'd1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Packet is a pure function of registered state, so it stays stable while stalled.
    always_comb begin
        l2i_request       = '0;
        l2i_request_valid = 1'b0;
        if (state_q == ST_LOAD_REQ || state_q == ST_STORE_REQ) begin
            l2i_request_valid      = 1'b1;
            l2i_request.core       = core_id_t'(CORE_ID);
            l2i_request.id         = local_thread_idx_t'(THREAD_ID);
            l2i_request.cache_type = CT_DCACHE;
            l2i_request.address    = addr_q[31:6];
            if (state_q == ST_STORE_REQ) begin
                l2i_request.packet_type = L2REQ_STORE_SYNC;
                l2i_request.data[lane_bit +: ATOMIC_WORD_WIDTH] = new_q;
                l2i_request.store_mask[mask_bit +: 4] = 4'hF;
            end else begin
                l2i_request.packet_type = L2REQ_LOAD_SYNC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            op_q           <= ATOMIC_ADD;
            addr_q         <= '0;
            operand_q      <= '0;
            old_q          <= '0;
            new_q          <= '0;
            retries_q      <= '0;
            done_success_q <= 1'b0;
            done_old_q     <= '0;
            done_retries_q <= '0;
`ifdef L2_ATOMIC_BACKOFF_EN
            backoff_q      <= '0;
`endif
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            operand_q      <= operand_d;
            old_q          <= old_d;
            new_q          <= new_d;
            retries_q      <= retries_d;
            done_success_q <= done_success_d;
            done_old_q     <= done_old_d;
            done_retries_q <= done_retries_d;
`ifdef L2_ATOMIC_BACKOFF_EN
            backoff_q      <= backoff_d;
`endif
        end
    end

    // A matching response of the wrong kind means the L2 and this FSM disagree.
    always_ff @(posedge clk) begin
        if (!reset && rsp_match && state_q == ST_LOAD_WAIT)
            assert (l2_response.packet_type == L2RSP_LOAD_ACK);
        if (!reset && rsp_match && state_q == ST_STORE_WAIT)
            assert (l2_response.packet_type == L2RSP_STORE_ACK);
    end

endmodule

// File: tb/tb_l2_atomic_requester.sv
// Directed bench with a behavioural sync-capable L2 and a done scoreboard.
// Honours L2_ATOMIC_BACKOFF_EN when checking retry gaps.
module tb_l2_atomic_requester;
    import l2_atomic_requester_pkg::*;

    localparam int CORE   = 1;
    localparam int THREAD = 2;
    localparam int MAXR   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    atomic_op_t    cmd_op;
    logic [31:0]   cmd_addr;
    logic [31:0]   cmd_operand;
    logic          done_valid;
    logic          done_success;
    logic [31:0]   done_old_value;
    logic [3:0]    done_retries;
    logic          l2i_request_valid;
    l2req_packet_t l2i_request;
    logic          l2_ready;
    logic          l2_response_valid;
    l2rsp_packet_t l2_response;

    always #5 clk = ~clk;

    l2_atomic_requester #(
        .CORE_ID     (CORE),
        .THREAD_ID   (THREAD),
        .MAX_RETRIES (MAXR)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_op            (cmd_op),
        .cmd_addr          (cmd_addr),
        .cmd_operand       (cmd_operand),
        .done_valid        (done_valid),
        .done_success      (done_success),
        .done_old_value    (done_old_value),
        .done_retries      (done_retries),
        .l2i_request_valid (l2i_request_valid),
        .l2i_request       (l2i_request),
        .l2_ready          (l2_ready),
        .l2_response_valid (l2_response_valid),
        .l2_response       (l2_response)
    );

    typedef struct packed {
        logic        s;
        logic [31:0] o;
        logic [3:0]  r;
    } done_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_seen = 0;
    done_t sb_q[$];

    logic [511:0] mem [logic [25:0]];
    logic         resv_valid = 1'b0;
    logic [25:0]  resv_line;
    l2rsp_packet_t pend_pkt;
    int           pend_cnt = -1;
    l2rsp_packet_t inj_q[$];
    int           lat = 1;
    int           stall_left = 0;
    logic         snap_valid = 1'b0;
    l2req_packet_t snap;
    logic         force_fail = 1'b0;
    logic         contend = 1'b0;
    logic [31:0]  contend_val;
    logic         inject = 1'b0;
    logic         drop_store = 1'b0;
    logic         store_seen = 1'b0;
    int           stores_in_cmd = 0;
    atomic_op_t   cur_op;
    logic [31:0]  cur_addr;
    logic [31:0]  cur_operand;
    logic [31:0]  model_old;
    logic         expect_store = 1'b0;
    int           fails_in_cmd = 0;
    logic         gap_armed = 1'b0;
    int           gap_exp = 0;
    int           fail_tick = -1;
    logic         prev_done = 1'b0;

    task automatic check(string tag, logic [639:0] obs, logic [639:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(atomic_op_t op, logic [31:0] a, logic [31:0] b);
        case (op)
            ATOMIC_ADD:  return a + b;
            ATOMIC_SWAP: return b;
            ATOMIC_AND:  return a & b;
            default:     return a | b;
        endcase
    endfunction

    function automatic logic [511:0] line_rd(logic [25:0] a);
        if (mem.exists(a)) return mem[a];
        return '0;
    endfunction

    function automatic l2rsp_packet_t mk_rsp(l2rsp_packet_type_t t, logic st,
                                             logic [511:0] d, int core, int id,
                                             cache_type_t ct);
        l2rsp_packet_t p;
        p             = '0;
        p.status      = st;
        p.packet_type = t;
        p.core        = core_id_t'(core);
        p.id          = local_thread_idx_t'(id);
        p.cache_type  = ct;
        p.address     = cur_addr[31:6];
        p.data        = d;
        return p;
    endfunction

    task automatic serve(l2req_packet_t rq);
        int           lane;
        logic [25:0]  line;
        logic [511:0] d;
        logic [511:0] exp_d;
        logic [63:0]  exp_m;
        logic         ok;
        lane = int'(cur_addr[5:2]);
        line = cur_addr[31:6];
        check("req_core", rq.core, CORE);
        check("req_id", rq.id, THREAD);
        check("req_ctype", rq.cache_type, CT_DCACHE);
        check("req_line", rq.address, line);
        if (!expect_store) begin
            check("req_type_load", rq.packet_type, L2REQ_LOAD_SYNC);
            check("load_mask", rq.store_mask, 64'd0);
            if (fail_tick >= 0) begin
                check("retry_gap", cyc - fail_tick, gap_exp);
                fail_tick = -1;
            end
            d          = line_rd(line);
            model_old  = d[lane*32 +: 32];
            resv_valid = 1'b1;
            resv_line  = line;
            pend_pkt   = mk_rsp(L2RSP_LOAD_ACK, 1'b0, d, CORE, THREAD, CT_DCACHE);
            if (contend) begin
                d[lane*32 +: 32] = contend_val;
                mem[line]  = d;
                resv_valid = 1'b0;
                contend    = 1'b0;
            end
            if (inject) begin
                inj_q.push_back(mk_rsp(L2RSP_LOAD_ACK, 1'b0, '1, CORE, THREAD ^ 1, CT_DCACHE));
                inj_q.push_back(mk_rsp(L2RSP_LOAD_ACK, 1'b0, '1, CORE + 1, THREAD, CT_DCACHE));
                inj_q.push_back(mk_rsp(L2RSP_LOAD_ACK, 1'b0, '1, CORE, THREAD, CT_ICACHE));
                inject = 1'b0;
            end
            expect_store = 1'b1;
            pend_cnt     = lat - 1;
        end else begin
            check("req_type_store", rq.packet_type, L2REQ_STORE_SYNC);
            exp_d = '0;
            exp_d[lane*32 +: 32] = ref_alu(cur_op, model_old, cur_operand);
            exp_m = '0;
            exp_m[lane*4 +: 4] = 4'hF;
            check("store_mask", rq.store_mask, exp_m);
            check("store_data", rq.data, exp_d);
            store_seen   = 1'b1;
            expect_store = 1'b0;
            stores_in_cmd++;
            if (!drop_store) begin
                ok = resv_valid && resv_line == line && !force_fail;
                resv_valid = 1'b0;
                if (ok) begin
                    d = line_rd(line);
                    d[lane*32 +: 32] = exp_d[lane*32 +: 32];
                    mem[line] = d;
                end else if (fails_in_cmd < MAXR) begin
                    gap_exp = 1;
`ifdef L2_ATOMIC_BACKOFF_EN
                    gap_exp += 1 << fails_in_cmd;
`endif
                    gap_armed = 1'b1;
                end
                if (!ok) fails_in_cmd++;
                pend_pkt = mk_rsp(L2RSP_STORE_ACK, ok, '0, CORE, THREAD, CT_DCACHE);
                pend_cnt = lat - 1;
            end
        end
    endtask

    task automatic tick();
        done_t e;
        @(negedge clk);
        cyc++;
        if (done_valid) begin
            check("done_pulse_len", prev_done, 1'b0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL done_unexpected observed=1 expected=0");
            end else begin
                e = sb_q.pop_front();
                check("done_success", done_success, e.s);
                check("done_old", done_old_value, e.o);
                check("done_retries", done_retries, e.r);
            end
            done_seen++;
        end
        prev_done = done_valid;
        l2_response_valid = 1'b0;
        if (pend_cnt == 0) begin
            l2_response_valid = 1'b1;
            l2_response       = pend_pkt;
            pend_cnt          = -1;
            if (pend_pkt.packet_type == L2RSP_STORE_ACK && gap_armed) begin
                fail_tick = cyc;
                gap_armed = 1'b0;
            end
        end else begin
            if (pend_cnt > 0) pend_cnt--;
            if (inj_q.size() > 0) begin
                l2_response_valid = 1'b1;
                l2_response       = inj_q.pop_front();
                check("wait_holds", l2i_request_valid, 1'b0);
            end
        end
        l2_ready = 1'b1;
        if (l2i_request_valid) begin
            if (stall_left > 0) begin
                l2_ready = 1'b0;
                if (!snap_valid) begin
                    snap       = l2i_request;
                    snap_valid = 1'b1;
                end else begin
                    check("stall_stable", l2i_request, snap);
                end
                stall_left--;
            end else begin
                if (snap_valid) begin
                    check("stall_stable", l2i_request, snap);
                    snap_valid = 1'b0;
                end
                serve(l2i_request);
            end
        end
    endtask

    task automatic do_cmd(atomic_op_t op, logic [31:0] addr, logic [31:0] operand,
                          logic succ, logic [31:0] old, logic [3:0] retr,
                          logic expect_done);
        int n;
        int target;
        cur_op        = op;
        cur_addr      = addr;
        cur_operand   = operand;
        fails_in_cmd  = 0;
        stores_in_cmd = 0;
        fail_tick     = -1;
        gap_armed     = 1'b0;
        expect_store  = 1'b0;
        store_seen    = 1'b0;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        check("cmd_ready", cmd_ready, 1'b1);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_addr    = addr;
        cmd_operand = operand;
        if (expect_done) sb_q.push_back(done_t'{succ, old, retr});
        target = done_seen + 1;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        if (expect_done) begin
            while (done_seen < target && n < 500) begin
                tick();
                n++;
            end
            if (done_seen < target) begin
                checks++;
                errors++;
                $error("FAIL done_timeout observed=none expected=done_valid");
            end
        end else begin
            while (!store_seen && n < 500) begin
                tick();
                n++;
            end
            if (!store_seen) begin
                checks++;
                errors++;
                $error("FAIL store_timeout observed=none expected=STORE_SYNC");
            end
        end
    endtask

    initial begin
        reset             = 1'b1;
        cmd_valid         = 1'b0;
        cmd_op            = ATOMIC_ADD;
        cmd_addr          = '0;
        cmd_operand       = '0;
        l2_ready          = 1'b1;
        l2_response_valid = 1'b0;
        l2_response       = '0;
        cur_addr          = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_done_valid", done_valid, 1'b0);
        check("rst_req_valid", l2i_request_valid, 1'b0);
        check("rst_req_pkt", l2i_request, '0);
        check("rst_done_vals", {done_success, done_old_value, done_retries}, '0);

        do_cmd(ATOMIC_ADD, 32'h48C0, 32'h5, 1'b1, 32'h0, 4'd0, 1'b1);
        do_cmd(ATOMIC_ADD, 32'h48C0, 32'h0, 1'b1, 32'h5, 4'd0, 1'b1);
        tick();
        check("hold_done_valid", done_valid, 1'b0);
        check("hold_old", done_old_value, 32'h5);
        check("hold_success", done_success, 1'b1);
        do_cmd(ATOMIC_ADD, 32'h48C0, 32'hFFFF_FFFF, 1'b1, 32'h5, 4'd0, 1'b1);
        do_cmd(ATOMIC_ADD, 32'h48C0, 32'h0, 1'b1, 32'h4, 4'd0, 1'b1);

        do_cmd(ATOMIC_SWAP, 32'h48CC, 32'hDEAD_BEEF, 1'b1, 32'h0, 4'd0, 1'b1);
        do_cmd(ATOMIC_ADD, 32'h48CC, 32'h0, 1'b1, 32'hDEAD_BEEF, 4'd0, 1'b1);
        do_cmd(ATOMIC_ADD, 32'h48C0, 32'h0, 1'b1, 32'h4, 4'd0, 1'b1);

        contend     = 1'b1;
        contend_val = 32'h100;
        do_cmd(ATOMIC_ADD, 32'h1000, 32'h7, 1'b1, 32'h100, 4'd1, 1'b1);
        check("contend_stores", stores_in_cmd, 2);
        do_cmd(ATOMIC_ADD, 32'h1000, 32'h0, 1'b1, 32'h107, 4'd0, 1'b1);

        lat    = 4;
        inject = 1'b1;
        do_cmd(ATOMIC_OR, 32'h1000, 32'hF0, 1'b1, 32'h107, 4'd0, 1'b1);
        lat = 1;
        do_cmd(ATOMIC_ADD, 32'h1000, 32'h0, 1'b1, 32'h1F7, 4'd0, 1'b1);

        do_cmd(ATOMIC_SWAP, 32'h2004, 32'h55, 1'b1, 32'h0, 4'd0, 1'b1);
        force_fail = 1'b1;
        do_cmd(ATOMIC_AND, 32'h2004, 32'h0F, 1'b0, 32'h55, 4'd2, 1'b1);
        check("fail_stores", stores_in_cmd, 3);
        force_fail = 1'b0;
        do_cmd(ATOMIC_ADD, 32'h2004, 32'h0, 1'b1, 32'h55, 4'd0, 1'b1);

        stall_left = 3;
        do_cmd(ATOMIC_SWAP, 32'h3008, 32'h1234, 1'b1, 32'h0, 4'd0, 1'b1);
        do_cmd(ATOMIC_ADD, 32'h3008, 32'h0, 1'b1, 32'h1234, 4'd0, 1'b1);

        drop_store = 1'b1;
        do_cmd(ATOMIC_ADD, 32'h4000, 32'h1, 1'b0, 32'h0, 4'd0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        check("mid_rst_req_valid", l2i_request_valid, 1'b0);
        check("mid_rst_done_vals", {done_valid, done_success, done_old_value, done_retries}, '0);
        drop_store   = 1'b0;
        resv_valid   = 1'b0;
        pend_cnt     = -1;
        expect_store = 1'b0;
        do_cmd(ATOMIC_ADD, 32'h4000, 32'h3, 1'b1, 32'h0, 4'd0, 1'b1);
        do_cmd(ATOMIC_ADD, 32'h4000, 32'h0, 1'b1, 32'h3, 4'd0, 1'b1);

        tick();
        tick();
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
